mem_port_arbiter: RTL and testbench

Shares one memory port between the instruction-fetch requester and the load/store requester of the multi-cycle core. Each requester gets a valid/ready request channel and a one-cycle response pulse. The arbiter latches the winning request, drives it to memory under a valid/ready handshake, waits for the memory response with a timeout watchdog, and returns the data to the owner. Only one transaction is outstanding at a time.

---
 rtl/mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between the instruction-fetch requester and the
// load/store requester. A winning request is latched in IDLE, presented to
// memory under a valid/ready handshake in REQ, its response is awaited in
// WAIT (guarded by a timeout watchdog), and a one-cycle response pulse is
// returned to the owner in RESP. Only one transaction is outstanding.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration between requesters
//                  undefined -> fixed priority, LSU always beats fetch
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in REQ+WAIT before an error response (1..65535)
//   ERR_DATA        rdata returned on a timeout
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   if_req_valid/if_req_ready       fetch request handshake, if_addr payload
//   if_rsp_valid/if_rdata/if_err    fetch response (one-cycle pulse)
//   ls_req_valid/ls_req_ready       load/store request handshake
//   ls_addr/ls_wdata/ls_ctrl        load/store payload (MEM_* encoding)
//   ls_rsp_valid/ls_rdata/ls_err    load/store response (one-cycle pulse)
//   mem_req_valid/mem_req_ready     memory request handshake
//   mem_addr/mem_wdata/mem_ctrl     memory request payload
//   mem_rsp_valid/mem_rdata         memory response
//   owner                           current or last grant (0 = fetch, 1 = LSU)
//   busy                            high whenever not in IDLE
// -----------------------------------------------------------------------------

package mem_port_arbiter_pkg;

    // Memory access control encoding: bit 3 marks a store, bits 1:0 the size.
    localparam logic [3:0] MEM_LOAD1   = 4'b0000;
    localparam logic [3:0] MEM_LOAD2   = 4'b0001;
    localparam logic [3:0] MEM_LOAD4   = 4'b0010;
    localparam logic [3:0] MEM_LOADU1  = 4'b0100;
    localparam logic [3:0] MEM_LOADU2  = 4'b0101;
    localparam logic [3:0] MEM_STORE1  = 4'b1000;
    localparam logic [3:0] MEM_STORE2  = 4'b1001;
    localparam logic [3:0] MEM_STORE4  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,

    // fetch requester
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,

    // load/store requester
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_ctrl,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,

    // memory port
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_ctrl,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,

    // status
    output logic        owner,
    output logic        busy
);

    // The watchdog fires on the TIMEOUT_CYCLES-th cycle spent in REQ+WAIT;
    // the counter holds the number of earlier REQ/WAIT cycles.
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        in_idle;
    logic        win_ls;
    logic        accept;
    logic        timeout_hit;
    logic        finish;
    logic [31:0] fin_data;
    logic        fin_err;

    assign in_idle     = (state_q == ST_IDLE);
    assign timeout_hit = (cnt_q == LAST_CNT);

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    // last_q = 1 means the LSU was granted last, so fetch wins the next
    // contention; it resets to 1 so fetch wins the very first one.
    logic last_q, last_d;

    assign win_ls = ls_req_valid && (!if_req_valid || !last_q);
    assign last_d = accept ? win_ls : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign win_ls = ls_req_valid;
`endif

    // Ready goes only to the winner, and only while it is actually valid.
    assign ls_req_ready = in_idle && win_ls;
    assign if_req_ready = in_idle && if_req_valid && !win_ls;
    assign accept       = ls_req_ready || if_req_ready;

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        finish     = 1'b0;
        fin_data   = mem_rdata;
        fin_err    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_REQ;
                    owner_d = win_ls;
                    cnt_d   = '0;
                    if (win_ls) begin
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                        ctrl_d  = ls_ctrl;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        ctrl_d  = MEM_LOAD4;
                    end
                end
            end

            ST_REQ: begin
                cnt_d = cnt_q + 16'd1;
                // A response in the same cycle as the ack (or the timeout)
                // is real data and takes precedence over the watchdog.
                if (mem_req_ready && mem_rsp_valid) begin
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    finish   = 1'b1;
                    fin_data = ERR_DATA;
                    fin_err  = 1'b1;
                end else if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_rsp_valid) begin
                    finish = 1'b1;
                end else if (timeout_hit) begin
                    finish   = 1'b1;
                    fin_data = ERR_DATA;
                    fin_err  = 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only the owner's rdata register moves; the other holds its value.
        if (finish) begin
            state_d = ST_RESP;
            err_d   = fin_err;
            if (owner_q) begin
                ls_rdata_d = fin_data;
            end else begin
                if_rdata_d = fin_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its _d value from before the edge regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ctrl_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_ctrl      = ctrl_q;

    assign if_rsp_valid  = (state_q == ST_RESP) && !owner_q;
    assign ls_rsp_valid  = (state_q == ST_RESP) &&  owner_q;
    assign if_err        = if_rsp_valid && err_q;
    assign ls_err        = ls_rsp_valid && err_q;
    assign if_rdata      = if_rdata_q;
    assign ls_rdata      = ls_rdata_q;

    assign owner         = owner_q;
    assign busy          = !in_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios with literal expectations followed by a randomized
// phase. A transaction-level reference model, evaluated on every falling
// clock edge, predicts all outputs from the accept cycle, the memory ack and
// response cycles and the timeout budget.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_ready;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [3:0]  ls_ctrl = '0;
    logic        ls_rsp_valid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_ctrl;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        owner;
    logic        busy;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES (T),
        .ERR_DATA       (ERR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rdata      (if_rdata),
        .if_err        (if_err),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_ctrl       (ls_ctrl),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rdata      (ls_rdata),
        .ls_err        (ls_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ctrl      (mem_ctrl),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .owner         (owner),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid  = 1'b0;
        ls_req_valid  = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Reference model: one record for the transaction in flight.
    // m_rsp is the cycle on which the response pulse is due (-1 = unknown).
    // -------------------------------------------------------------------------
    bit          m_act    = 1'b0;
    bit          m_own    = 1'b0;
    bit          m_acked  = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_owner  = 1'b0;
    int          m_acc    = 0;
    int          m_rsp    = -1;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [3:0]  m_ctrl   = '0;
    logic [31:0] m_data   = '0;
    logic [31:0] m_if_rd  = '0;
    logic [31:0] m_ls_rd  = '0;
    bit          m_if_kn  = 1'b1;
    bit          m_ls_kn  = 1'b1;
    bit          e_rsp, e_req, e_wls;
`ifdef MEM_ARB_RR_EN
    bit          m_last_ls = 1'b1;
`endif

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_busy", busy, 0);
            check("rst_owner", owner, 0);
            check("rst_mem_req_valid", mem_req_valid, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_if_rsp_valid", if_rsp_valid, 0);
            check("rst_ls_rsp_valid", ls_rsp_valid, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_ls_rdata", ls_rdata, 0);
            m_act   = 1'b0;
            m_owner = 1'b0;
            m_if_rd = '0;
            m_ls_rd = '0;
            m_if_kn = 1'b1;
            m_ls_kn = 1'b1;
`ifdef MEM_ARB_RR_EN
            m_last_ls = 1'b1;
`endif
        end else begin
            e_rsp = m_act && (m_rsp == cyc);
            e_req = m_act && !m_acked && (m_rsp < 0);
`ifdef MEM_ARB_RR_EN
            // On contention the side not granted last wins.
            if (ls_req_valid && if_req_valid) e_wls = !m_last_ls;
            else                              e_wls = ls_req_valid;
`else
            e_wls = ls_req_valid;
`endif
            if (e_rsp) begin
                if (m_own) begin
                    m_ls_kn = (m_ctrl != MEM_STORE4);
                    m_ls_rd = m_data;
                end else begin
                    m_if_kn = 1'b1;
                    m_if_rd = m_data;
                end
            end

            check("m_busy", busy, m_act);
            check("m_owner", owner, m_owner);
            check("m_mem_req_valid", mem_req_valid, e_req);
            check("m_ls_ready", ls_req_ready, !m_act && e_wls);
            check("m_if_ready", if_req_ready, !m_act && if_req_valid && !e_wls);
            check("m_if_rsp_valid", if_rsp_valid, e_rsp && !m_own);
            check("m_ls_rsp_valid", ls_rsp_valid, e_rsp && m_own);
            check("m_if_err", if_err, e_rsp && !m_own && m_err);
            check("m_ls_err", ls_err, e_rsp && m_own && m_err);
            if (m_if_kn) check("m_if_rdata", if_rdata, m_if_rd);
            if (m_ls_kn) check("m_ls_rdata", ls_rdata, m_ls_rd);
            if (e_req) begin
                check("m_mem_addr", mem_addr, m_addr);
                check("m_mem_wdata", mem_wdata, m_wdata);
                check("m_mem_ctrl", mem_ctrl, m_ctrl);
            end

            // Advance the model with the inputs seen at the coming edge.
            if (m_act) begin
                if (e_rsp) begin
                    m_act = 1'b0;
                end else if (m_rsp < 0) begin
                    if (mem_rsp_valid && (m_acked || mem_req_ready)) begin
                        m_rsp  = cyc + 1;
                        m_data = mem_rdata;
                        m_err  = 1'b0;
                    end else if (cyc - m_acc == T) begin
                        m_rsp  = cyc + 1;
                        m_data = ERR;
                        m_err  = 1'b1;
                    end
                    if (mem_req_ready) m_acked = 1'b1;
                end
            end else if (ls_req_valid || if_req_valid) begin
                m_act   = 1'b1;
                m_acc   = cyc;
                m_rsp   = -1;
                m_acked = 1'b0;
                m_own   = e_wls;
                m_owner = e_wls;
                m_addr  = e_wls ? ls_addr : if_addr;
                m_wdata = e_wls ? ls_wdata : 32'd0;
                m_ctrl  = e_wls ? ls_ctrl : MEM_LOAD4;
`ifdef MEM_ARB_RR_EN
                m_last_ls = e_wls;
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus with literal expectations
    // -------------------------------------------------------------------------
    bit exp_ls;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_owner", owner, 0);
        check("reset_mem_ctrl", mem_ctrl, 0);
        check("reset_if_ready", if_req_ready, 0);
        tick();
        rst_n = 1'b1;

        // Single fetch, immediate ack, data one cycle later.
        tick(); if_req_valid = 1'b1; if_addr = 32'h100;
        #1 check("t1_if_ready", if_req_ready, 1);
        tick(); if_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1 check("t1_mem_req_valid", mem_req_valid, 1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_mem_ctrl", mem_ctrl, MEM_LOAD4);
        check("t1_mem_wdata", mem_wdata, 0);
        tick(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h00000013;
        tick(); mem_rsp_valid = 1'b0;
        #1 check("t1_if_rsp_valid", if_rsp_valid, 1);
        check("t1_if_rdata", if_rdata, 32'h00000013);
        check("t1_ls_rsp_valid", ls_rsp_valid, 0);
        tick();
        #1 check("t1_pulse_once", if_rsp_valid, 0);

        // Store held off by memory for 4 cycles.
        tick(); ls_req_valid = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hCAFEF00D; ls_ctrl = MEM_STORE4;
        #1 check("t2_ls_ready", ls_req_ready, 1);
        tick(); ls_req_valid = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1 check("t2_hold_valid", mem_req_valid, 1);
            check("t2_hold_addr", mem_addr, 32'h200);
            check("t2_hold_wdata", mem_wdata, 32'hCAFEF00D);
            check("t2_hold_ctrl", mem_ctrl, MEM_STORE4);
            tick();
        end
        mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0BADF00D;
        #1 check("t2_no_early_rsp", ls_rsp_valid, 0);
        tick(); mem_rsp_valid = 1'b0;
        #1 check("t2_ls_rsp_valid", ls_rsp_valid, 1);
        check("t2_ls_err", ls_err, 0);
        check("t2_if_rsp_valid", if_rsp_valid, 0);

        // Contention, four rounds, minimum-latency memory.
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_ls = (k % 2) == 1;
`else
            exp_ls = 1'b1;
`endif
            tick();
            if_req_valid = 1'b1; if_addr = 32'h1000 + 32'(k);
            ls_req_valid = 1'b1; ls_addr = 32'h2000 + 32'(k); ls_ctrl = MEM_LOAD4;
            #1 check("t3_ls_ready", ls_req_ready, exp_ls);
            check("t3_if_ready", if_req_ready, !exp_ls);
            tick(); if_req_valid = 1'b0; ls_req_valid = 1'b0;
            mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h77000000 + 32'(k);
            #1 check("t3_owner", owner, exp_ls);
            check("t3_mem_addr", mem_addr, exp_ls ? 32'h2000 + 32'(k) : 32'h1000 + 32'(k));
            tick(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
            #1 check("t3_ls_rsp", ls_rsp_valid, exp_ls);
            check("t3_if_rsp", if_rsp_valid, !exp_ls);
            check("t3_rdata", exp_ls ? ls_rdata : if_rdata, 32'h77000000 + 32'(k));
        end

        // Timeout with no response, then a late response that must be ignored.
        tick(); ls_req_valid = 1'b1; ls_addr = 32'h300; ls_ctrl = MEM_LOAD4;
        tick(); ls_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0;
        for (int i = 2; i < 9; i++) begin
            #1 check("t4_no_rsp_yet", ls_rsp_valid, 0);
            tick();
        end
        #1 check("t4_ls_rsp_valid", ls_rsp_valid, 1);
        check("t4_ls_err", ls_err, 1);
        check("t4_ls_rdata", ls_rdata, 32'hDEADBEEF);
        tick(); tick(); tick(); mem_rsp_valid = 1'b1; mem_rdata = 32'h55555555;
        #1 check("t4_late_ignored", ls_rsp_valid, 0);
        check("t4_idle", busy, 0);
        tick(); mem_rsp_valid = 1'b0;
        #1 check("t4_late_no_pulse_ls", ls_rsp_valid, 0);
        check("t4_late_no_pulse_if", if_rsp_valid, 0);
        check("t4_rdata_held", ls_rdata, 32'hDEADBEEF);

        // Response exactly on the timeout cycle wins.
        tick(); if_req_valid = 1'b1; if_addr = 32'h400;
        tick(); if_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0;
        for (int i = 2; i < 8; i++) tick();
        mem_rsp_valid = 1'b1; mem_rdata = 32'h12345678;
        tick(); mem_rsp_valid = 1'b0;
        #1 check("t5_if_rsp_valid", if_rsp_valid, 1);
        check("t5_if_err", if_err, 0);
        check("t5_if_rdata", if_rdata, 32'h12345678);

        // Reset while waiting on memory.
        tick(); ls_req_valid = 1'b1; ls_addr = 32'h500; ls_ctrl = MEM_LOAD4;
        tick(); ls_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("t6_busy", busy, 0);
        check("t6_owner", owner, 0);
        check("t6_mem_req_valid", mem_req_valid, 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_mem_wdata", mem_wdata, 0);
        check("t6_mem_ctrl", mem_ctrl, 0);
        check("t6_if_rdata", if_rdata, 0);
        check("t6_ls_rdata", ls_rdata, 0);
        check("t6_ls_rsp_valid", ls_rsp_valid, 0);
        check("t6_ls_err", ls_err, 0);
        tick(); mem_rsp_valid = 1'b1; mem_rdata = 32'h66666666;
        tick(); mem_rsp_valid = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("t6_no_rsp", ls_rsp_valid, 0);
            tick();
        end
        if_req_valid = 1'b1; if_addr = 32'h600;
        tick(); if_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hA5A5A5A5;
        tick(); mem_rsp_valid = 1'b0;
        #1 check("t6_fetch_rsp", if_rsp_valid, 1);
        check("t6_fetch_rdata", if_rdata, 32'hA5A5A5A5);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            tick();
            if_req_valid  = $urandom_range(0, 99) < 40;
            if_addr       = $urandom;
            ls_req_valid  = $urandom_range(0, 99) < 40;
            ls_addr       = $urandom;
            ls_wdata      = $urandom;
            ls_ctrl       = ($urandom_range(0, 1) == 1) ? MEM_STORE4 : MEM_LOAD4;
            mem_req_ready = $urandom_range(0, 99) < 50;
            mem_rsp_valid = $urandom_range(0, 99) < 15;
            mem_rdata     = $urandom;
        end
        tick();
        idle_inputs();
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
